// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores over a req/ack bus, stalls
// upstream while an access is outstanding, and loads the MEM/WB register.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int RD_W    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ctrl_mem,
    input  logic [31:0]     rd_mem,
    input  logic [31:0]     alu_result,
    input  logic [31:0]     write_data1,
    input  logic [31:0]     pc4_mem,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [31:0]     dmem_addr,
    output logic [31:0]     dmem_wdata,
    input  logic [31:0]     dmem_rdata,
    input  logic            dmem_ack,
    output logic            ctrl_wb,
    output logic [RD_W-1:0] rd_wb,
    output logic [31:0]     wb_data,
    output logic            bus_err,
    output logic            misalign_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t          state;
    logic [7:0]      cnt;
    logic            rw_q;
    logic            ld_q;
    logic [RD_W-1:0] rd_q;
    logic [31:0]     val_q;

    logic        mem_op;
    logic        aligned;
    logic [1:0]  wb_sel;
    logic [31:0] alu_val;
    logic        unused_rd_bits;

    assign mem_op         = ctrl_mem[4] | ctrl_mem[3];
    assign aligned        = (alu_result[1:0] == 2'b00);
    assign wb_sel         = ctrl_mem[2:1];
    // wb_sel 01 without a memory access falls back to the ALU result
    assign alu_val        = (wb_sel == 2'b10) ? pc4_mem : alu_result;
    assign unused_rd_bits = ^rd_mem[31:RD_W];

    always_comb begin
        stall = 1'b0;
        if (state == IDLE)
            stall = mem_op & aligned;
        else
            stall = ~dmem_ack & (cnt != CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rw_q         <= 1'b0;
            ld_q         <= 1'b0;
            rd_q         <= '0;
            val_q        <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            ctrl_wb      <= 1'b0;
            rd_wb        <= '0;
            wb_data      <= '0;
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!mem_op) begin
                        ctrl_wb <= ctrl_mem[0];
                        rd_wb   <= rd_mem[RD_W-1:0];
                        wb_data <= alu_val;
                    end else if (!aligned) begin
                        misalign_err <= 1'b1;
                        ctrl_wb      <= 1'b0;
                    end else begin
                        // Write-back fields are captured here so the access does
                        // not depend on upstream holding its outputs afterwards.
                        state      <= BUSY;
                        cnt        <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= ctrl_mem[3];
                        dmem_addr  <= {alu_result[31:2], 2'b00};
                        dmem_wdata <= write_data1;
                        rw_q       <= ctrl_mem[0];
                        ld_q       <= (wb_sel == 2'b01);
                        rd_q       <= rd_mem[RD_W-1:0];
                        val_q      <= alu_val;
                        ctrl_wb    <= 1'b0;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        dmem_req <= 1'b0;
                        ctrl_wb  <= rw_q;
                        rd_wb    <= rd_q;
                        wb_data  <= ld_q ? dmem_rdata : val_q;
                    end else if (cnt == CNT_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        ctrl_wb  <= 1'b0;
                    end else begin
                        cnt     <= cnt + 8'd1;
                        ctrl_wb <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: an instruction-level reference model predicts
// stall length, write-back result, bus fields and sticky error flags.
module tb_mem_stage;

    localparam int TIMEOUT = 4;
    localparam int RD_W    = 5;
    localparam int NEVER   = 1000;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      ctrl_mem;
    logic [31:0]     rd_mem, alu_result, write_data1, pc4_mem;
    logic            stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0]     dmem_addr, dmem_wdata, dmem_rdata;
    logic            ctrl_wb, bus_err, misalign_err;
    logic [RD_W-1:0] rd_wb;
    logic [31:0]     wb_data;

    int n_cmp = 0;
    int n_err = 0;

    // slave_mem is the bus slave's storage; model_mem is the model's expectation
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];
    bit exp_berr = 0;
    bit exp_mis  = 0;

    mem_stage #(.TIMEOUT(TIMEOUT), .RD_W(RD_W)) dut (
        .clk(clk), .reset(reset), .ctrl_mem(ctrl_mem), .rd_mem(rd_mem),
        .alu_result(alu_result), .write_data1(write_data1), .pc4_mem(pc4_mem),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .ctrl_wb(ctrl_wb), .rd_wb(rd_wb), .wb_data(wb_data),
        .bus_err(bus_err), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_C0DE;
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    task automatic check_reset_vals();
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_ctrl_wb", {31'b0, ctrl_wb}, 32'd0);
        chk("rst_rd_wb", 32'(rd_wb), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        chk("rst_misalign_err", {31'b0, misalign_err}, 32'd0);
    endtask

    // d = BUSY cycles without ack before the acking cycle (>= TIMEOUT: never acked)
    task automatic run_instr(input logic [4:0] c, input logic [31:0] rd, input logic [31:0] alu,
                             input logic [31:0] wd, input logic [31:0] pc, input int d);
        bit mop, mis, done, saw_req;
        int exp_stall, stall_cnt, busy, cyc;
        bit exp_rw;
        logic [31:0] exp_val, old;
        logic [31:0] got_addr, got_wdata;
        logic got_we;
        mop = c[4] | c[3];
        mis = mop && (alu[1:0] != 2'b00);
        exp_rw = 1'b0;
        exp_val = 32'd0;
        exp_stall = 0;
        got_addr = 32'd0; got_wdata = 32'd0; got_we = 1'b0;
        if (!mop) begin
            exp_rw = c[0];
            exp_val = (c[2:1] == 2'b10) ? pc : alu;
        end else if (mis) begin
            exp_mis = 1;
        end else if (d >= TIMEOUT) begin
            exp_stall = TIMEOUT;
            exp_berr = 1;
        end else begin
            exp_stall = 1 + d;
            exp_rw = c[0];
            old = model_rd(alu);
            exp_val = (c[2:1] == 2'b01) ? old : (c[2:1] == 2'b10) ? pc : alu;
            if (c[3]) model_mem[alu] = wd;
        end

        ctrl_mem = c; rd_mem = rd; alu_result = alu; write_data1 = wd; pc4_mem = pc;
        done = 0; saw_req = 0; stall_cnt = 0; busy = 0; cyc = 0;
        while (!done && cyc < 64) begin
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            if (dmem_req) begin
                saw_req = 1;
                busy++;
                if (busy == 1) begin
                    got_addr = dmem_addr; got_we = dmem_we; got_wdata = dmem_wdata;
                end
                if (busy == d + 1) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = slave_rd(dmem_addr);
                    if (dmem_we) slave_mem[dmem_addr] = dmem_wdata;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                dmem_ack = 1'b1;
            end
            #1;
            if (stall) stall_cnt++;
            else done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        dmem_ack = 1'b0;
        if (!done) chk("cycle_bound", 32'd0, 32'd1);

        chk("stall_cycles", stall_cnt, exp_stall);
        chk("req_seen", {31'b0, saw_req}, {31'b0, mop && !mis});
        chk("req_dropped", {31'b0, dmem_req}, 32'd0);
        chk("ctrl_wb", {31'b0, ctrl_wb}, {31'b0, exp_rw});
        if (exp_rw) begin
            chk("rd_wb", 32'(rd_wb), 32'(rd[RD_W-1:0]));
            chk("wb_data", wb_data, exp_val);
        end
        if (mop && !mis) begin
            chk("dmem_addr", got_addr, alu);
            chk("dmem_we", {31'b0, got_we}, {31'b0, c[3]});
            if (c[3]) chk("dmem_wdata", got_wdata, wd);
        end
        chk("bus_err", {31'b0, bus_err}, {31'b0, exp_berr});
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
    endtask

    initial begin
        logic [4:0] c;
        logic [31:0] a;
        int d;
        reset = 1'b1; ctrl_mem = '0; rd_mem = '0; alu_result = '0;
        write_data1 = '0; pc4_mem = '0; dmem_rdata = '0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_vals();

        slave_mem[32'h100] = 32'hDEAD_BEEF;
        model_mem[32'h100] = 32'hDEAD_BEEF;
        run_instr(5'b00001, 32'd7, 32'h1234, 32'd0, 32'd0, 0);
        run_instr(5'b10011, 32'd9, 32'h100, 32'd0, 32'h8, 3);
        run_instr(5'b01000, 32'd3, 32'h104, 32'hA5A5_A5A5, 32'hC, 0);
        run_instr(5'b10011, 32'd4, 32'h104, 32'd0, 32'h10, 0);
        run_instr(5'b10011, 32'd5, 32'h108, 32'd0, 32'h14, NEVER);
        run_instr(5'b00001, 32'd6, 32'h55, 32'd0, 32'h18, 0);
        run_instr(5'b10011, 32'd8, 32'h102, 32'd0, 32'h1C, 0);
        run_instr(5'b00101, 32'd1, 32'h99, 32'd0, 32'h44, 0);
        run_instr(5'b10011, 32'd2, 32'h10C, 32'd0, 32'h48, TIMEOUT - 1);
        run_instr(5'b11001, 32'd2, 32'h110, 32'h1357_9BDF, 32'h4C, 1);

        for (int i = 0; i < 300; i++) begin
            c = 5'($urandom);
            a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            d = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, TIMEOUT - 1);
            run_instr(c, $urandom, a, $urandom, $urandom, d);
        end

        // reset while an access is outstanding, then a late ack
        ctrl_mem = 5'b10011; alu_result = 32'h120; rd_mem = 32'd3;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; ctrl_mem = 5'b00000;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_berr = 0; exp_mis = 0;
        check_reset_vals();
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 dmem_ack = 1'b0;
        chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
        chk("late_ack_ctrl_wb", {31'b0, ctrl_wb}, 32'd0);
        chk("late_ack_stall", {31'b0, stall}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
